// File: rtl/n64_reset_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// n64_reset_scheduler_pkg
// Shared types and constants for the N64 reset scheduler: FSM state encoding,
// counter widths, default timing constants and the counter-load helper.
// ----------------------------------------------------------------------------
package n64_reset_scheduler_pkg;

  // FSM states; the encoding is visible to the CPU through state_o.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_DRIVE   = 2'b10,
    ST_HOLDOFF = 2'b11
  } state_e;

  // One down-counter is shared by the frame timeout, the pulse and the holdoff,
  // so it is as wide as the widest of the three.
  localparam int unsigned CNT_W = 22;
  localparam int unsigned FRM_W = 4;

  // Default timing constants (4 MHz controller clock).
  localparam logic [15:0] DEF_IGR_COMBO       = 16'h0000;
  localparam logic [3:0]  DEF_HOLD_FRAMES     = 4'd4;
  localparam logic [19:0] DEF_FRAME_TO_CYCLES = 20'd80000;
  localparam logic [19:0] DEF_PULSE_CYCLES    = 20'hFFFFF;
  localparam logic [21:0] DEF_HOLDOFF_CYCLES  = 22'h3D0900;

  // A phase lasting N cycles loads N-1 and leaves when the counter reads 0.
  // A zero length is treated as one cycle rather than wrapping.
  function automatic logic [CNT_W-1:0] cnt_load(input logic [CNT_W-1:0] cycles);
    logic [CNT_W-1:0] val;
    if (cycles == 22'd0) begin
      val = 22'd0;
    end else begin
      val = cycles - 22'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/n64_reset_scheduler_if.sv
// ----------------------------------------------------------------------------
// n64_reset_scheduler_if
// Groups the scheduler's request inputs and status outputs.
//   ctrl_data_i/ctrl_data_valid_i : sniffed controller word + new-word strobe
//   use_igr_i                     : IGR reset enable
//   cpu_rst_req_i / cpu_rst_ack_o : CPU reset request pulse / accept pulse
//   N64_nRST_i                    : sensed (asynchronous) reset line level
//   drv_rst_o                     : 1 = pull the N64 reset line low
//   rst_busy_o, state_o           : status for CPU readback
// master = the side producing requests, slave = the scheduler.
// ----------------------------------------------------------------------------
interface n64_reset_scheduler_if;
  logic [31:0] ctrl_data_i;
  logic        ctrl_data_valid_i;
  logic        use_igr_i;
  logic        cpu_rst_req_i;
  logic        N64_nRST_i;
  logic        drv_rst_o;
  logic        cpu_rst_ack_o;
  logic        rst_busy_o;
  logic [1:0]  state_o;

  modport master (
    output ctrl_data_i, ctrl_data_valid_i, use_igr_i, cpu_rst_req_i, N64_nRST_i,
    input  drv_rst_o, cpu_rst_ack_o, rst_busy_o, state_o
  );

  modport slave (
    input  ctrl_data_i, ctrl_data_valid_i, use_igr_i, cpu_rst_req_i, N64_nRST_i,
    output drv_rst_o, cpu_rst_ack_o, rst_busy_o, state_o
  );
endinterface

// File: rtl/n64_reset_scheduler_sync.sv
// ----------------------------------------------------------------------------
// n64_reset_scheduler_sync
// Two-flop synchroniser with a reset preset value (used for the sensed nRST
// line, which idles high, so it presets to 1 and no false console reset is
// seen coming out of reset).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   d_i          : asynchronous input
//   q_o          : synchronised output (2 cycles latency)
// ----------------------------------------------------------------------------
module n64_reset_scheduler_sync #(
  parameter int unsigned       WIDTH  = 1,
  parameter logic [WIDTH-1:0]  PRESET = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage synchroniser chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= PRESET;
      sync_q <= PRESET;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/n64_reset_scheduler.sv
// ----------------------------------------------------------------------------
// n64_reset_scheduler
// Sole owner of the N64 reset line. Arbitrates the IGR button combo (qualified
// over HOLD_FRAMES consecutive matching frames) and CPU requests, drives a
// PULSE_CYCLES reset pulse, then holds off for HOLDOFF_CYCLES. A console reset
// seen on the sensed line also enters the holdoff.
//   CTRL_CLK : controller-domain clock
//   CTRL_RST : asynchronous active-high reset
//   bus      : request/status interface (slave side), all outputs registered
// ----------------------------------------------------------------------------
module n64_reset_scheduler
  import n64_reset_scheduler_pkg::*;
#(
  parameter logic [15:0] IGR_COMBO       = DEF_IGR_COMBO,
  parameter logic [3:0]  HOLD_FRAMES     = DEF_HOLD_FRAMES,
  parameter logic [19:0] FRAME_TO_CYCLES = DEF_FRAME_TO_CYCLES,
  parameter logic [19:0] PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter logic [21:0] HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic                  CTRL_CLK,
  input  logic                  CTRL_RST,
  n64_reset_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] FRAME_TO_LOAD = cnt_load({2'b00, FRAME_TO_CYCLES});
  localparam logic [CNT_W-1:0] PULSE_LOAD    = cnt_load({2'b00, PULSE_CYCLES});
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD  = cnt_load(HOLDOFF_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic              drv_q, drv_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              nrst_sync_s;
  logic              match_s;
  logic [FRM_W-1:0]  frame_inc_s;
  logic [CNT_W-1:0]  cnt_dec_s;

  n64_reset_scheduler_sync #(
    .WIDTH  (1),
    .PRESET (1'b1)
  ) u_nrst_sync (
    .clk_i (CTRL_CLK),
    .rst_i (CTRL_RST),
    .d_i   (bus.N64_nRST_i),
    .q_o   (nrst_sync_s)
  );

  assign match_s     = bus.use_igr_i & bus.ctrl_data_valid_i &
                       (bus.ctrl_data_i[15:0] == IGR_COMBO);
  assign frame_inc_s = (frame_q == 4'hF) ? frame_q : (frame_q + 4'd1);
  assign cnt_dec_s   = (cnt_q == 22'd0) ? cnt_q : (cnt_q - 22'd1);

  // State, counters and registered outputs; async reset also drops the line drive.
  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 22'd0;
      frame_q <= 4'd0;
      drv_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      drv_q   <= drv_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_rst_req_i) begin
          state_d = ST_DRIVE;
          cnt_d   = PULSE_LOAD;
          frame_d = 4'd0;
          ack_d   = 1'b1;
        end else if (match_s) begin
          if (HOLD_FRAMES <= 4'd1) begin
            state_d = ST_DRIVE;
            cnt_d   = PULSE_LOAD;
            frame_d = 4'd0;
          end else begin
            state_d = ST_ARMED;
            cnt_d   = FRAME_TO_LOAD;
            frame_d = 4'd1;
          end
        end else if (!nrst_sync_s) begin
          // Console-initiated reset: just stay out of its way.
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_LOAD;
          frame_d = 4'd0;
        end else begin
          frame_d = 4'd0;
        end
      end

      ST_ARMED: begin
        if (bus.cpu_rst_req_i) begin
          // CPU request wins even when the combo completes in the same cycle.
          state_d = ST_DRIVE;
          cnt_d   = PULSE_LOAD;
          frame_d = 4'd0;
          ack_d   = 1'b1;
        end else if (!bus.use_igr_i) begin
          state_d = ST_IDLE;
          cnt_d   = 22'd0;
          frame_d = 4'd0;
        end else if (bus.ctrl_data_valid_i) begin
          if (match_s) begin
            if (frame_inc_s >= HOLD_FRAMES) begin
              state_d = ST_DRIVE;
              cnt_d   = PULSE_LOAD;
              frame_d = 4'd0;
            end else begin
              frame_d = frame_inc_s;
              cnt_d   = FRAME_TO_LOAD;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 22'd0;
            frame_d = 4'd0;
          end
        end else if (cnt_q == 22'd0) begin
          // No new frame within the timeout: combo was released or sniffer stalled.
          state_d = ST_IDLE;
          frame_d = 4'd0;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end

      ST_DRIVE: begin
        // Sensed line is ignored here: it only reflects our own drive.
        if (cnt_q == 22'd0) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_LOAD;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end

      ST_HOLDOFF: begin
        if (!nrst_sync_s) begin
          // Line still held low (console button): restart the holdoff window.
          cnt_d = HOLDOFF_LOAD;
        end else if (cnt_q == 22'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 22'd0;
        frame_d = 4'd0;
      end
    endcase

    drv_d  = (state_d == ST_DRIVE);
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_HOLDOFF);
  end

  assign bus.drv_rst_o     = drv_q;
  assign bus.cpu_rst_ack_o = ack_q;
  assign bus.rst_busy_o    = busy_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_n64_reset_scheduler.sv
// ----------------------------------------------------------------------------
// tb_n64_reset_scheduler
// Randomised and directed stimulus for n64_reset_scheduler. Expected reset
// episodes (ack count, drive length, busy length) are queued when stimulus is
// issued; a monitor measures each episode the DUT produces and compares.
// ----------------------------------------------------------------------------
module tb_n64_reset_scheduler;

  localparam logic [15:0] COMBO   = 16'hC0F3;
  localparam int          HOLD    = 3;
  localparam int          TO      = 100;
  localparam int          PULSE   = 50;
  localparam int          HOLDOFF = 200;

  localparam int S_IDLE = 0, S_ARMED = 1, S_DRIVE = 2, S_HOLDOFF = 3;

  typedef struct {
    int ack;
    int drv;
    int bmin;
    int bmax;
  } ep_t;

  logic clk;
  logic rst;
  n64_reset_scheduler_if bus ();

  ep_t exp_q[$];
  int  n_total;
  int  n_pass;

  n64_reset_scheduler #(
    .IGR_COMBO       (COMBO),
    .HOLD_FRAMES     (4'd3),
    .FRAME_TO_CYCLES (20'd100),
    .PULSE_CYCLES    (20'd50),
    .HOLDOFF_CYCLES  (22'd200)
  ) dut (
    .CTRL_CLK (clk),
    .CTRL_RST (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ep_t mk_ep(input int ack, input int drv, input int bmin, input int bmax);
    ep_t e;
    e.ack = ack; e.drv = drv; e.bmin = bmin; e.bmax = bmax;
    return e;
  endfunction

  // Monitor: measures each busy episode and compares it with the queue head.
  int  ep_ack, ep_drv, ep_busy;
  bit  in_ep;
  initial begin
    in_ep = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_ep = 1'b0;
      end else if (!in_ep) begin
        if (bus.rst_busy_o) begin
          in_ep   = 1'b1;
          ep_busy = 1;
          ep_drv  = int'(bus.drv_rst_o);
          ep_ack  = int'(bus.cpu_rst_ack_o);
        end else if (bus.drv_rst_o || bus.cpu_rst_ack_o) begin
          n_total++;
          $display("FAIL idle_outputs: drv=%0b ack=%0b while not busy (t=%0t)",
                   bus.drv_rst_o, bus.cpu_rst_ack_o, $time);
        end
      end else if (bus.rst_busy_o) begin
        ep_busy++;
        ep_drv += int'(bus.drv_rst_o);
        ep_ack += int'(bus.cpu_rst_ack_o);
      end else begin
        in_ep = 1'b0;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_episode: busy=%0d drv=%0d ack=%0d, none expected",
                   ep_busy, ep_drv, ep_ack);
        end else begin
          ep_t e;
          e = exp_q.pop_front();
          check("ep_ack_count", ep_ack, e.ack);
          check("ep_drv_len", ep_drv, e.drv);
          n_total++;
          if (ep_busy >= e.bmin && ep_busy <= e.bmax) begin
            n_pass++;
          end else begin
            $display("FAIL ep_busy_len: got %0d expected %0d..%0d", ep_busy, e.bmin, e.bmax);
          end
        end
      end
    end
  end

  // Present one frame at a negedge; returns at the next negedge with valid low.
  task automatic send_frame(input logic [31:0] w, input bit cpu);
    bus.ctrl_data_i       = w;
    bus.ctrl_data_valid_i = 1'b1;
    bus.cpu_rst_req_i     = cpu;
    @(negedge clk);
    bus.ctrl_data_valid_i = 1'b0;
    bus.cpu_rst_req_i     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((bus.rst_busy_o || bus.state_o != 2'b00) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", {31'd0, (k < budget)}, 32'd1);
    idle_cycles(3);
  endtask

  function automatic logic [31:0] match_word();
    logic [31:0] w;
    w = {$urandom_range(0, 65535), COMBO};
    return w;
  endfunction

  function automatic logic [31:0] miss_word();
    logic [15:0] lo;
    lo = 16'($urandom_range(0, 65535));
    if (lo == COMBO) lo = lo ^ 16'h0001;
    return {16'($urandom), lo};
  endfunction

  // Reference model of combo qualification: consecutive matches with gaps <= TO.
  task automatic run_frames(input int nf, input int pct_match);
    int  cnt, gap;
    bit  m;
    cnt = 0;
    for (int f = 0; f < nf; f++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(95, 140) : $urandom_range(1, 60);
      m   = ($urandom_range(0, 99) < pct_match);
      if (f > 0) idle_cycles(gap - 1);
      send_frame(m ? match_word() : miss_word(), 1'b0);
      if (m) cnt = (cnt > 0 && gap <= TO) ? cnt + 1 : 1;
      else   cnt = 0;
      if (cnt >= HOLD) begin
        exp_q.push_back(mk_ep(0, PULSE, PULSE + HOLDOFF, PULSE + HOLDOFF));
        check("rand_state_fire", {30'd0, bus.state_o}, S_DRIVE);
        break;
      end else begin
        check("rand_state", {30'd0, bus.state_o}, (cnt > 0) ? S_ARMED : S_IDLE);
      end
    end
    idle_cycles(TO + 5);
    wait_idle(1000);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.ctrl_data_i       = 32'd0;
    bus.ctrl_data_valid_i = 1'b0;
    bus.use_igr_i         = 1'b1;
    bus.cpu_rst_req_i     = 1'b0;
    bus.N64_nRST_i        = 1'b1;

    // Reset state
    idle_cycles(3);
    check("rst_drv", {31'd0, bus.drv_rst_o}, 32'd0);
    check("rst_ack", {31'd0, bus.cpu_rst_ack_o}, 32'd0);
    check("rst_busy", {31'd0, bus.rst_busy_o}, 32'd0);
    check("rst_state", {30'd0, bus.state_o}, S_IDLE);
    rst = 1'b0;
    idle_cycles(5);

    // IGR combo: 3 matching frames 40 cycles apart
    send_frame(match_word(), 1'b0);
    check("igr_armed1", {30'd0, bus.state_o}, S_ARMED);
    idle_cycles(39);
    send_frame(match_word(), 1'b0);
    check("igr_armed2", {30'd0, bus.state_o}, S_ARMED);
    idle_cycles(39);
    exp_q.push_back(mk_ep(0, PULSE, PULSE + HOLDOFF, PULSE + HOLDOFF));
    send_frame(match_word(), 1'b0);
    check("igr_drive", {30'd0, bus.state_o}, S_DRIVE);
    check("igr_drv_on", {31'd0, bus.drv_rst_o}, 32'd1);
    wait_idle(1000);

    // Two matches then a zero word -> back to IDLE
    send_frame(match_word(), 1'b0);
    idle_cycles(19);
    send_frame(match_word(), 1'b0);
    idle_cycles(19);
    send_frame(32'h0000_0000, 1'b0);
    check("zero_word_idle", {30'd0, bus.state_o}, S_IDLE);
    idle_cycles(10);

    // Two matches then a 150-cycle gap -> timeout to IDLE, then a match restarts at 1
    send_frame(match_word(), 1'b0);
    idle_cycles(19);
    send_frame(match_word(), 1'b0);
    idle_cycles(149);
    check("gap_timeout_idle", {30'd0, bus.state_o}, S_IDLE);
    send_frame(match_word(), 1'b0);
    idle_cycles(19);
    send_frame(match_word(), 1'b0);
    check("restart_armed", {30'd0, bus.state_o}, S_ARMED);
    idle_cycles(TO + 5);
    check("restart_timeout", {30'd0, bus.state_o}, S_IDLE);

    // Gap of exactly TO is still accepted
    send_frame(match_word(), 1'b0);
    idle_cycles(TO - 1);
    send_frame(match_word(), 1'b0);
    idle_cycles(TO - 1);
    exp_q.push_back(mk_ep(0, PULSE, PULSE + HOLDOFF, PULSE + HOLDOFF));
    send_frame(match_word(), 1'b0);
    check("gap_boundary_drive", {30'd0, bus.state_o}, S_DRIVE);
    wait_idle(1000);

    // CPU request in IDLE, second request during DRIVE, third during HOLDOFF
    exp_q.push_back(mk_ep(1, PULSE, PULSE + HOLDOFF, PULSE + HOLDOFF));
    bus.cpu_rst_req_i = 1'b1;
    @(negedge clk);
    bus.cpu_rst_req_i = 1'b0;
    check("cpu_ack", {31'd0, bus.cpu_rst_ack_o}, 32'd1);
    @(negedge clk);
    check("cpu_ack_one_cycle", {31'd0, bus.cpu_rst_ack_o}, 32'd0);
    idle_cycles(10);
    bus.cpu_rst_req_i = 1'b1;
    @(negedge clk);
    bus.cpu_rst_req_i = 1'b0;
    check("cpu_ack_in_drive", {31'd0, bus.cpu_rst_ack_o}, 32'd0);
    idle_cycles(60);
    bus.cpu_rst_req_i = 1'b1;
    @(negedge clk);
    bus.cpu_rst_req_i = 1'b0;
    check("cpu_ack_in_holdoff", {31'd0, bus.cpu_rst_ack_o}, 32'd0);
    check("holdoff_state", {30'd0, bus.state_o}, S_HOLDOFF);
    wait_idle(1000);

    // CPU request coincident with the third matching frame -> one DRIVE with ack
    send_frame(match_word(), 1'b0);
    idle_cycles(19);
    send_frame(match_word(), 1'b0);
    idle_cycles(19);
    exp_q.push_back(mk_ep(1, PULSE, PULSE + HOLDOFF, PULSE + HOLDOFF));
    send_frame(match_word(), 1'b1);
    check("coincident_drive", {30'd0, bus.state_o}, S_DRIVE);
    check("coincident_ack", {31'd0, bus.cpu_rst_ack_o}, 32'd1);
    wait_idle(1000);

    // Console reset: line low 500 cycles -> HOLDOFF, exit ~200 after release
    exp_q.push_back(mk_ep(0, 0, 500 + HOLDOFF - 4, 500 + HOLDOFF + 2));
    bus.N64_nRST_i = 1'b0;
    idle_cycles(10);
    check("console_holdoff", {30'd0, bus.state_o}, S_HOLDOFF);
    idle_cycles(490);
    bus.N64_nRST_i = 1'b1;
    idle_cycles(HOLDOFF - 10);
    check("console_still_busy", {31'd0, bus.rst_busy_o}, 32'd1);
    wait_idle(1000);

    // IGR disabled: matching frames do nothing
    bus.use_igr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_frame(match_word(), 1'b0);
      check("igr_off_idle", {30'd0, bus.state_o}, S_IDLE);
      idle_cycles(19);
    end
    bus.use_igr_i = 1'b1;

    // IGR disabled while ARMED -> IDLE
    send_frame(match_word(), 1'b0);
    idle_cycles(9);
    send_frame(match_word(), 1'b0);
    bus.use_igr_i = 1'b0;
    @(negedge clk);
    bus.use_igr_i = 1'b1;
    check("igr_drop_idle", {30'd0, bus.state_o}, S_IDLE);
    idle_cycles(5);

    // Randomised frame sequences against the model
    for (int s = 0; s < 12; s++) begin
      run_frames($urandom_range(3, 8), 75);
    end

    // Async reset mid-DRIVE releases the line immediately
    bus.cpu_rst_req_i = 1'b1;
    @(negedge clk);
    bus.cpu_rst_req_i = 1'b0;
    idle_cycles(20);
    check("pre_rst_drv", {31'd0, bus.drv_rst_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_drv", {31'd0, bus.drv_rst_o}, 32'd0);
    check("async_rst_state", {30'd0, bus.state_o}, S_IDLE);
    check("async_rst_busy", {31'd0, bus.rst_busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(5);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
